// File: rtl/vga_tile_pkg.sv
// Shared constants for the snake tile display: geometry, tile types, palette,
// sweep FSM states and the cell-index helper.
package vga_tile_pkg;

    localparam int CELL_SHIFT = 4;
    localparam int COLS       = 40;
    localparam int ROWS       = 30;
    localparam int TYPE_W     = 3;
    localparam int CELLS      = COLS * ROWS;
    localparam int IDX_W      = 11;

    // Sized bounds so comparisons against the 6-bit x / 5-bit y stay width-matched
    localparam logic [5:0] COL_LIMIT = 6'(COLS);
    localparam logic [4:0] ROW_LIMIT = 5'(ROWS);
    localparam logic [5:0] LAST_COL  = 6'(COLS - 1);
    localparam logic [4:0] LAST_ROW  = 5'(ROWS - 1);

    localparam logic [TYPE_W-1:0] T_EMPTY = 3'd0;
    localparam logic [TYPE_W-1:0] T_HEAD  = 3'd1;
    localparam logic [TYPE_W-1:0] T_BODY  = 3'd2;
    localparam logic [TYPE_W-1:0] T_FOOD  = 3'd3;
    localparam logic [TYPE_W-1:0] T_WALL  = 3'd4;

    // Colours are bbbb_gggg_rrrr
    localparam logic [11:0] C_EMPTY = 12'h000;
    localparam logic [11:0] C_HEAD  = 12'h0F0;
    localparam logic [11:0] C_BODY  = 12'h0A0;
    localparam logic [11:0] C_FOOD  = 12'h00F;
    localparam logic [11:0] C_WALL  = 12'h888;
    localparam logic [11:0] C_GRID  = 12'h222;

    typedef enum logic {ST_IDLE, ST_SWEEP} sweep_state_t;

    // y*40 + x without a multiplier: (y<<5) + (y<<3) + x
    function automatic logic [IDX_W-1:0] cell_index(input logic [4:0] y, input logic [5:0] x);
        logic [IDX_W-1:0] yy;
        yy = {6'd0, y};
        return (yy << 5) + (yy << 3) + {5'd0, x};
    endfunction

    // Reserved types 5..7 render as black
    function automatic logic [11:0] palette(input logic [TYPE_W-1:0] t);
        case (t)
            T_HEAD:  return C_HEAD;
            T_BODY:  return C_BODY;
            T_FOOD:  return C_FOOD;
            T_WALL:  return C_WALL;
            default: return C_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/vga_tile_source_if.sv
// Pixel read bus between the VGA controller (master) and the pixel source (slave).
interface vga_tile_source_if;
    logic [8:0]  row_addr;
    logic [9:0]  col_addr;
    logic        rdn;
    logic [11:0] d_in;

    modport master (output row_addr, col_addr, rdn, input d_in);
    modport slave  (input row_addr, col_addr, rdn, output d_in);
endinterface

// File: rtl/vga_tile_ram.sv
// Tile map storage: one shared write port (sweep has priority over the game),
// an asynchronous display read port and a registered read-back port.
module vga_tile_ram
    import vga_tile_pkg::*;
(
    input  logic              vga_clk,
    input  logic              clrn,
    input  logic              sweep_we,
    input  logic [IDX_W-1:0]  sweep_idx,
    input  logic [TYPE_W-1:0] sweep_data,
    input  logic              game_we,
    input  logic [IDX_W-1:0]  game_idx,
    input  logic [TYPE_W-1:0] game_data,
    input  logic [IDX_W-1:0]  disp_idx,
    output logic [TYPE_W-1:0] disp_type,
    input  logic [IDX_W-1:0]  rb_idx,
    output logic [TYPE_W-1:0] rb_type
);
    logic [TYPE_W-1:0] mem [0:CELLS-1];
    logic              we;
    logic [IDX_W-1:0]  w_idx;
    logic [TYPE_W-1:0] w_data;
    logic [TYPE_W-1:0] rb_reg;

    // Write port arbitration: a sweep cycle always wins
    always_comb begin
        we     = sweep_we || game_we;
        w_idx  = game_idx;
        w_data = game_data;
        if (sweep_we) begin
            w_idx  = sweep_idx;
            w_data = sweep_data;
        end
    end

    // Storage write; contents are never reset, only rewritten by the sweep
    always_ff @(posedge vga_clk) begin
        if (we) begin
            mem[w_idx] <= w_data;
        end
    end

    assign disp_type = mem[disp_idx];

    // Read-back register; samples the pre-write value on a same-cell collision
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            rb_reg <= '0;
        end else begin
            rb_reg <= mem[rb_idx];
        end
    end

    assign rb_type = rb_reg;
endmodule

// File: rtl/vga_tile_source.sv
// Snake-game pixel source: decodes VGA pixel reads into tile colours, takes game
// writes / read-backs, and runs a clear+border sweep after reset or on request.
// Optional grid overlay enabled by defining GRID_LINES_EN.
module vga_tile_source
    import vga_tile_pkg::*;
(
    input  logic              vga_clk,
    input  logic              clrn,
    vga_tile_source_if.slave  pix,
    input  logic              wr_en,
    input  logic [5:0]        wr_x,
    input  logic [4:0]        wr_y,
    input  logic [TYPE_W-1:0] wr_type,
    output logic              wr_ack,
    input  logic [5:0]        rd_x,
    input  logic [4:0]        rd_y,
    output logic [TYPE_W-1:0] rd_type,
    input  logic              clr_req,
    output logic              busy
);
    sweep_state_t      state_reg, state_next;
    logic [5:0]        sx_reg, sx_next;
    logic [4:0]        sy_reg, sy_next;
    logic              sweep_we;
    logic [TYPE_W-1:0] sweep_data;
    logic              game_we;
    logic              wr_ack_reg;
    logic              rd_oob_reg;
    logic              rd_in_range;
    logic [TYPE_W-1:0] rb_type;
    logic [4:0]        disp_y;
    logic [5:0]        disp_x;
    logic              disp_in_range;
    logic [TYPE_W-1:0] disp_type;
    logic [11:0]       pix_colour;

    // Sweep state and cell position register
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            state_reg <= ST_SWEEP;
            sx_reg    <= '0;
            sy_reg    <= '0;
        end else begin
            state_reg <= state_next;
            sx_reg    <= sx_next;
            sy_reg    <= sy_next;
        end
    end

    // Sweep sequencing: raster order over all cells, one per cycle
    always_comb begin
        state_next = state_reg;
        sx_next    = sx_reg;
        sy_next    = sy_reg;
        sweep_we   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (clr_req) begin
                    state_next = ST_SWEEP;
                    sx_next    = '0;
                    sy_next    = '0;
                end
            end
            ST_SWEEP: begin
                sweep_we = 1'b1;
                if (sx_reg == LAST_COL) begin
                    sx_next = '0;
                    if (sy_reg == LAST_ROW) begin
                        state_next = ST_IDLE;
                    end else begin
                        sy_next = sy_reg + 5'd1;
                    end
                end else begin
                    sx_next = sx_reg + 6'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign sweep_data = (sx_reg == 6'd0 || sx_reg == LAST_COL ||
                         sy_reg == 5'd0 || sy_reg == LAST_ROW) ? T_WALL : T_EMPTY;
    assign busy       = (state_reg == ST_SWEEP);
    assign game_we    = wr_en && !busy && (wr_x < COL_LIMIT) && (wr_y < ROW_LIMIT);
    assign rd_in_range = (rd_x < COL_LIMIT) && (rd_y < ROW_LIMIT);

    // Write acknowledge and out-of-range flag for the read-back path
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            wr_ack_reg <= 1'b0;
            rd_oob_reg <= 1'b0;
        end else begin
            wr_ack_reg <= game_we;
            rd_oob_reg <= !rd_in_range;
        end
    end

    assign wr_ack  = wr_ack_reg;
    assign rd_type = rd_oob_reg ? T_WALL : rb_type;

    assign disp_y        = pix.row_addr[8:CELL_SHIFT];
    assign disp_x        = pix.col_addr[9:CELL_SHIFT];
    assign disp_in_range = (disp_y < ROW_LIMIT) && (disp_x < COL_LIMIT);

    vga_tile_ram u_ram (
        .vga_clk    (vga_clk),
        .clrn       (clrn),
        .sweep_we   (sweep_we),
        .sweep_idx  (cell_index(sy_reg, sx_reg)),
        .sweep_data (sweep_data),
        .game_we    (game_we),
        .game_idx   (cell_index(wr_y, wr_x)),
        .game_data  (wr_type),
        .disp_idx   (disp_in_range ? cell_index(disp_y, disp_x) : '0),
        .disp_type  (disp_type),
        .rb_idx     (rd_in_range ? cell_index(rd_y, rd_x) : '0),
        .rb_type    (rb_type)
    );

    // Display colour: combinational so it settles within the pixel clock
    always_comb begin
        pix_colour = C_EMPTY;
        if (!pix.rdn && disp_in_range) begin
            pix_colour = palette(disp_type);
`ifdef GRID_LINES_EN
            if (state_reg == ST_IDLE && disp_type != T_WALL &&
                (pix.row_addr[3:0] == 4'd0 || pix.col_addr[3:0] == 4'd0)) begin
                pix_colour = C_GRID;
            end
`endif
        end
    end

`ifndef GRID_LINES_EN
    // Low address bits only matter for the grid overlay
    logic unused_pix_low;
    assign unused_pix_low = ^{pix.row_addr[3:0], pix.col_addr[3:0]};
`endif

    assign pix.d_in = pix_colour;
endmodule
